if_id_buffer: RTL and testbench

- Two-entry instruction buffer between the fetch stage and the decode stage.
- Captures PC, instruction word and fetch-side trap flags from fetch; presents them to decode with a valid/stall handshake.
- Decouples a decode stall from the fetch pipe and discards wrong-path instructions on branch/jump, trap entry or mret.
- Produces the fetch-side `pipe_stall` term through `if_ready`.

---
 rtl/if_id_buffer.sv | 125 ++++++++++++
 tb/tb_if_id_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction buffer: circular queue of DEPTH entries holding pc, inst and fetch trap flags.
// Latency: an entry accepted at edge N is presented on id_* after edge N; there is no bypass while the buffer is empty.
// Backpressure: if_ready drops when full (registered count only); a decode stall holds the head entry; flush kills all entries.
module if_id_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid,
    input  logic [XLEN-1:0]              if_pc,
    input  logic [XLEN-1:0]              if_inst,
    input  logic                         if_int_flag,
    input  logic                         if_exp_flag,
    input  logic                         if_inst_addr_misal,
    output logic                         if_ready,
    input  logic                         flush,
    input  logic                         id_stall,
    output logic                         id_valid,
    output logic [XLEN-1:0]              id_pc,
    output logic [XLEN-1:0]              id_inst,
    output logic                         id_int_flag,
    output logic                         id_exp_flag,
    output logic                         id_inst_addr_misal,
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // One buffered fetch entry; flags stay bit-exact with their own pc/inst.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            int_flag;
        logic            exp_flag;
        logic            inst_addr_misal;
    } entry_t;

    entry_t          mem_q   [DEPTH];
    entry_t          mem_d   [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push;
    logic            pop;
    entry_t          head;

    // Handshake terms come from registered count only, so fetch sees no input-to-output path.
    always_comb begin
        if_ready = (count_q != CW'(DEPTH));
        id_valid = (count_q != '0);
        push     = if_valid & if_ready & ~flush;
        pop      = id_valid & ~id_stall & ~flush;
    end

    // Next-state for storage, pointers and count; flush wins over everything and drops any same-cycle push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q].pc              = if_pc;
                mem_d[wr_ptr_q].inst            = if_inst;
                mem_d[wr_ptr_q].int_flag        = if_int_flag;
                mem_d[wr_ptr_q].exp_flag        = if_exp_flag;
                mem_d[wr_ptr_q].inst_addr_misal = if_inst_addr_misal;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset clears entries too so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head presentation; an empty buffer shows a NOP with zero pc and flags, since stale entries are never cleared.
    always_comb begin
        head               = mem_q[rd_ptr_q];
        occupancy          = count_q;
        id_pc              = '0;
        id_inst            = NOP_INST;
        id_int_flag        = 1'b0;
        id_exp_flag        = 1'b0;
        id_inst_addr_misal = 1'b0;
        if (id_valid) begin
            id_pc              = head.pc;
            id_inst            = head.inst;
            id_int_flag        = head.int_flag;
            id_exp_flag        = head.exp_flag;
            id_inst_addr_misal = head.inst_addr_misal;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, single entry, stall fill, streaming, flush, flags, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants in each step.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_int_flag;
    logic        if_exp_flag;
    logic        if_inst_addr_misal;
    logic        if_ready;
    logic        flush;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_int_flag;
    logic        id_exp_flag;
    logic        id_inst_addr_misal;
    logic [1:0]  occupancy;

    int passed = 0;
    int total  = 0;

    if_id_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .if_valid           (if_valid),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_int_flag        (if_int_flag),
        .if_exp_flag        (if_exp_flag),
        .if_inst_addr_misal (if_inst_addr_misal),
        .if_ready           (if_ready),
        .flush              (flush),
        .id_stall           (id_stall),
        .id_valid           (id_valid),
        .id_pc              (id_pc),
        .id_inst            (id_inst),
        .id_int_flag        (id_int_flag),
        .id_exp_flag        (id_exp_flag),
        .id_inst_addr_misal (id_inst_addr_misal),
        .occupancy          (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        if_int_flag = 1'b0; if_exp_flag = 1'b0; if_inst_addr_misal = 1'b0;
        flush = 1'b0; id_stall = 1'b0;
        step(); step();

        // reset state
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_id_inst", id_inst, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'd0);
        rst = 1'b0;
        step();
        chk("rel_id_valid", 32'(id_valid), 32'd0);

        // single entry
        offer(32'h0, 32'h0050_0093);
        step();
        chk("single_valid", 32'(id_valid), 32'd1);
        chk("single_inst", id_inst, 32'h0050_0093);
        chk("single_occ", 32'(occupancy), 32'd1);
        if_valid = 1'b0;
        step();
        chk("single_drain_valid", 32'(id_valid), 32'd0);
        chk("single_drain_inst", id_inst, 32'h0000_0013);

        // stall fill
        id_stall = 1'b1;
        offer(32'h4, 32'hAAAA_0004);
        step();
        chk("fill1_occ", 32'(occupancy), 32'd1);
        offer(32'h8, 32'hAAAA_0008);
        step();
        chk("fill2_occ", 32'(occupancy), 32'd2);
        chk("fill2_ready", 32'(if_ready), 32'd0);
        chk("fill2_head", id_pc, 32'h4);
        offer(32'hC, 32'hAAAA_000C);
        step();
        chk("fill3_occ", 32'(occupancy), 32'd2);
        chk("fill3_head", id_pc, 32'h4);
        if_valid = 1'b0;
        id_stall = 1'b0;
        chk("drain_head0_inst", id_inst, 32'hAAAA_0004);
        step();
        chk("drain_head1_pc", id_pc, 32'h8);
        chk("drain_head1_inst", id_inst, 32'hAAAA_0008);
        chk("drain_occ1", 32'(occupancy), 32'd1);
        step();
        chk("drain_empty", 32'(id_valid), 32'd0);
        chk("drain_ready", 32'(if_ready), 32'd1);

        // streaming
        for (int i = 0; i < 8; i++) begin
            offer(32'(4 * i), 32'h1000 + 32'(i));
            step();
            chk("stream_occ", 32'(occupancy), 32'd1);
            chk("stream_pc", id_pc, 32'(4 * i));
            chk("stream_inst", id_inst, 32'h1000 + 32'(i));
        end
        if_valid = 1'b0;
        step();
        chk("stream_end_occ", 32'(occupancy), 32'd0);

        // flush with concurrent offer
        id_stall = 1'b1;
        offer(32'h10, 32'hBBBB_0010);
        step();
        offer(32'h14, 32'hBBBB_0014);
        step();
        chk("pre_flush_occ", 32'(occupancy), 32'd2);
        offer(32'h18, 32'hBBBB_0018);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_inst", id_inst, 32'h0000_0013);
        chk("flush_ready", 32'(if_ready), 32'd1);
        offer(32'h100, 32'hCCCC_0100);
        step();
        chk("post_flush_occ", 32'(occupancy), 32'd1);
        chk("post_flush_pc", id_pc, 32'h100);
        if_valid = 1'b0;
        id_stall = 1'b0;
        step();
        chk("post_flush_empty", 32'(id_valid), 32'd0);

        // flag propagation
        offer(32'h6, 32'hDDDD_0006);
        if_inst_addr_misal = 1'b1;
        if_exp_flag = 1'b1;
        step();
        chk("flag1_pc", id_pc, 32'h6);
        chk("flag1_misal", 32'(id_inst_addr_misal), 32'd1);
        chk("flag1_exp", 32'(id_exp_flag), 32'd1);
        chk("flag1_int", 32'(id_int_flag), 32'd0);
        offer(32'h8, 32'hDDDD_0008);
        if_inst_addr_misal = 1'b0;
        if_exp_flag = 1'b0;
        step();
        chk("flag2_pc", id_pc, 32'h8);
        chk("flag2_misal", 32'(id_inst_addr_misal), 32'd0);
        chk("flag2_exp", 32'(id_exp_flag), 32'd0);
        if_valid = 1'b0;
        step();

        // asynchronous reset mid-operation
        id_stall = 1'b1;
        offer(32'h20, 32'hEEEE_0020);
        if_int_flag = 1'b1;
        step();
        offer(32'h24, 32'hEEEE_0024);
        if_int_flag = 1'b0;
        step();
        if_valid = 1'b0;
        chk("pre_arst_occ", 32'(occupancy), 32'd2);
        chk("pre_arst_int", 32'(id_int_flag), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(id_valid), 32'd0);
        chk("arst_ready", 32'(if_ready), 32'd1);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_inst", id_inst, 32'h0000_0013);
        chk("arst_pc", id_pc, 32'd0);
        chk("arst_int", 32'(id_int_flag), 32'd0);
        step();
        rst = 1'b0;
        offer(32'h200, 32'hFFFF_0200);
        step();
        chk("after_arst_occ", 32'(occupancy), 32'd1);
        chk("after_arst_pc", id_pc, 32'h200);
        if_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
